// File: rtl/axi4_simple_master.sv
// axi4_simple_master: turns a single-word request/response interface into
// single-beat AXI4 read/write transactions, one outstanding at a time.
module axi4_simple_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  // requester side
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      busy,
  // write address channel
  output logic [ADDR_WIDTH-1:0]     M_AXI_awaddr,
  output logic [7:0]                M_AXI_awlen,
  output logic [2:0]                M_AXI_awsize,
  output logic [1:0]                M_AXI_awburst,
  output logic [1:0]                M_AXI_awlock,
  output logic [3:0]                M_AXI_awcache,
  output logic [2:0]                M_AXI_awprot,
  output logic [3:0]                M_AXI_awregion,
  output logic [3:0]                M_AXI_awqos,
  output logic                      M_AXI_awvalid,
  input  logic                      M_AXI_awready,
  // write data channel
  output logic [DATA_WIDTH-1:0]     M_AXI_wdata,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_wstrb,
  output logic                      M_AXI_wlast,
  output logic                      M_AXI_wvalid,
  input  logic                      M_AXI_wready,
  // write response channel
  input  logic [1:0]                M_AXI_bresp,
  input  logic                      M_AXI_bvalid,
  output logic                      M_AXI_bready,
  // read address channel
  output logic [ADDR_WIDTH-1:0]     M_AXI_araddr,
  output logic [7:0]                M_AXI_arlen,
  output logic [2:0]                M_AXI_arsize,
  output logic [1:0]                M_AXI_arburst,
  output logic [1:0]                M_AXI_arlock,
  output logic [3:0]                M_AXI_arcache,
  output logic [2:0]                M_AXI_arprot,
  output logic [3:0]                M_AXI_arregion,
  output logic [3:0]                M_AXI_arqos,
  output logic                      M_AXI_arvalid,
  input  logic                      M_AXI_arready,
  // read data channel
  input  logic [DATA_WIDTH-1:0]     M_AXI_rdata,
  input  logic [1:0]                M_AXI_rresp,
  input  logic                      M_AXI_rlast,
  input  logic                      M_AXI_rvalid,
  output logic                      M_AXI_rready
);

  localparam int STRB = DATA_WIDTH / 8;
  localparam int SIZE = $clog2(STRB);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~(ADDR_WIDTH'(STRB - 1));

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_B,
    S_RD_A,
    S_RD_R,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic                  r_armed;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB-1:0]       r_wstrb;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic                  r_first;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [1:0]            r_rsp_resp;
  logic                  r_rsp_write;

  logic                  w_accept;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_b_hs;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_rsp_hs;

  // Handshake and output decode; valid/ready outputs come straight from
  // registered state so they are all low while ARESETN is asserted.
  assign req_ready     = r_armed && (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign M_AXI_awvalid = (r_state == S_WR) && !r_aw_done;
  assign M_AXI_wvalid  = (r_state == S_WR) && !r_w_done;
  assign M_AXI_wlast   = M_AXI_wvalid;
  assign M_AXI_bready  = (r_state == S_WR_B);
  assign M_AXI_arvalid = (r_state == S_RD_A);
  assign M_AXI_rready  = (r_state == S_RD_R);
  assign rsp_valid     = (r_state == S_RESP);

  assign w_accept = req_valid && req_ready;
  assign w_aw_hs  = M_AXI_awvalid && M_AXI_awready;
  assign w_w_hs   = M_AXI_wvalid && M_AXI_wready;
  assign w_b_hs   = M_AXI_bvalid && M_AXI_bready;
  assign w_ar_hs  = M_AXI_arvalid && M_AXI_arready;
  assign w_r_hs   = M_AXI_rvalid && M_AXI_rready;
  assign w_rsp_hs = rsp_valid && rsp_ready;

  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_resp  = r_rsp_resp;

  assign M_AXI_awaddr   = r_addr;
  assign M_AXI_araddr   = r_addr;
  assign M_AXI_wdata    = r_wdata;
  assign M_AXI_wstrb    = r_wstrb;
  assign M_AXI_awlen    = '0;
  assign M_AXI_arlen    = '0;
  assign M_AXI_awsize   = 3'(SIZE);
  assign M_AXI_arsize   = 3'(SIZE);
  assign M_AXI_awburst  = 2'b01;
  assign M_AXI_arburst  = 2'b01;
  assign M_AXI_awlock   = '0;
  assign M_AXI_arlock   = '0;
  assign M_AXI_awcache  = '0;
  assign M_AXI_arcache  = '0;
  assign M_AXI_awprot   = '0;
  assign M_AXI_arprot   = '0;
  assign M_AXI_awregion = '0;
  assign M_AXI_arregion = '0;
  assign M_AXI_awqos    = '0;
  assign M_AXI_arqos    = '0;

  // State register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; WR completes when both channels are done, counting a
  // handshake happening in the current cycle as done.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = req_write ? S_WR : S_RD_A;
        end
      end
      S_WR: begin
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
          w_next = S_WR_B;
        end
      end
      S_WR_B: begin
        if (w_b_hs) begin
          w_next = S_RESP;
        end
      end
      S_RD_A: begin
        if (w_ar_hs) begin
          w_next = S_RD_R;
        end
      end
      S_RD_R: begin
        if (w_r_hs && M_AXI_rlast) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (w_rsp_hs) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture, per-channel done flags and response latching
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_armed     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_first     <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
      r_rsp_write <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (w_accept) begin
        r_addr    <= req_addr & ADDR_MASK;
        r_wdata   <= req_wdata;
        r_wstrb   <= req_wstrb;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_first   <= 1'b1;
      end
      if (w_aw_hs) begin
        r_aw_done <= 1'b1;
      end
      if (w_w_hs) begin
        r_w_done <= 1'b1;
      end
      if (w_b_hs) begin
        r_rsp_rdata <= '0;
        r_rsp_resp  <= M_AXI_bresp;
        r_rsp_write <= 1'b1;
      end
      // only the first read beat is kept; extra beats are drained and dropped
      if (w_r_hs && r_first) begin
        r_rsp_rdata <= M_AXI_rdata;
        r_rsp_resp  <= M_AXI_rresp;
        r_rsp_write <= 1'b0;
        r_first     <= 1'b0;
      end
    end
  end

endmodule

// File: doc/axi4_simple_master.md
Name: axi4_simple_master

Overview:
- Upstream AXI4 master stage that turns a simple single-word request/response interface (used by the CPU ALU) into single-beat AXI4 read or write transactions toward the memory slave.
- One transaction outstanding at a time.
- Drives all five AXI4 channels.
- Returns the read data and response code to the requester.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width (32 or 64); STRB = DATA_WIDTH/8

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETN  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid&&req_ready
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  write data
req_wstrb  in  STRB  write byte strobes
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  response accepted
rsp_write  out  1  response belongs to a write
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_resp  out  2  AXI response code (bresp or rresp)
busy  out  1  high in every state except IDLE
M_AXI_awaddr/awlen/awsize/awburst/awvalid  out  ADDR_WIDTH/8/3/2/1  write address channel
M_AXI_awready  in  1
M_AXI_wdata/wstrb/wlast/wvalid  out  DATA_WIDTH/STRB/1/1  write data channel
M_AXI_wready  in  1
M_AXI_bresp/bvalid  in  2/1;  M_AXI_bready  out  1
M_AXI_araddr/arlen/arsize/arburst/arvalid  out  ADDR_WIDTH/8/3/2/1  read address channel
M_AXI_arready  in  1
M_AXI_rdata/rresp/rlast/rvalid  in  DATA_WIDTH/2/1/1;  M_AXI_rready  out  1
M_AXI_awlock/arlock out 2, awcache/arcache out 4, awprot/arprot out 3, awregion/arregion out 4, awqos/arqos out 4  constant 0

Behaviour:
Reset:
- ARESETN low asynchronously forces state IDLE.
- All valid/ready outputs 0, rsp_rdata 0, rsp_resp 0, rsp_write 0, busy 0.
- Address/data registers 0.
- Reset mid-transaction abandons it immediately with no response.

Constant fields:
- awlen=arlen=0.
- awburst=arburst=2'b01 (INCR).
- awsize=arsize=log2(STRB).
- wlast=1 whenever wvalid.
- Addresses are registered req_addr with the low log2(STRB) bits forced to 0.

States: IDLE, WR, WR_B, RD_A, RD_R, RESP.

IDLE:
- req_ready=1.
- On accept, capture addr/wdata/wstrb/write.
- Write: go to WR with awvalid=1 and wvalid=1 asserted together on the next cycle.
- Read: go to RD_A with arvalid=1.
- Minimum latency from accept to AXI valid is 1 cycle.

WR:
- awvalid and wvalid are independent.
- Each drops the cycle after its own handshake and sets aw_done / w_done.
- Must tolerate wready before, with, or after awready, including wready held low until the address handshake.
- Same-cycle completion of both handshakes goes straight to WR_B.
- Payload stays stable while valid is high.

WR_B:
- bready=1.
- On bvalid: latch bresp into rsp_resp, rsp_rdata=0, rsp_write=1, bready drops, go to RESP.

RD_A:
- arvalid=1 until arready.
- Then go to RD_R with rready=1.

RD_R:
- On the first rvalid beat: latch rdata and rresp.
- rlast=1: go to RESP.
- rlast=0 (protocol violation): stay with rready=1, discard further beats until the rvalid&&rlast beat, then go to RESP.
- rsp_resp is the first-beat code.
- rsp_write=0.

RESP:
- rsp_valid=1 with data stable until rsp_ready.
- Then rsp_valid drops and state returns to IDLE.
- req_ready rises the same cycle, so a new request can be accepted one cycle after rsp_ready.
- A request presented while not IDLE waits; there is no queuing.

Other:
- bvalid/rvalid arriving in an unexpected state are ignored, since bready/rready are 0 there.
- No timeout.

Test Plan:
- Write req addr=0x10, wdata=0xDEADBEEF, wstrb=0xF; slave gives awready 1 cycle after awvalid and wready only after the aw handshake, then bresp=00 -> awaddr=0x10, awsize=2, awlen=0, wlast=1; rsp_valid with rsp_write=1, rsp_resp=00, rsp_rdata=0.
- Read req addr=0x13 after the above; slave returns rdata=0xDEADBEEF, rresp=00, rlast=1 -> araddr=0x10; rsp_rdata=0xDEADBEEF, rsp_resp=00, rsp_write=0.
- Write with wready asserted before awready, then both in the same cycle in a second run -> exactly one handshake per channel, single bready phase, response correct in both runs.
- Read with slave rresp=10 and rsp_ready held low 5 cycles -> rsp_valid and rsp_resp=10 held stable 5 cycles; req_ready stays 0 until 1 cycle after rsp_ready.
- Read where the slave sends 3 beats (rlast only on beat 3) -> rsp_rdata is beat 1, all beats accepted, single rsp_valid.
- ARESETN asserted during WR after only the aw handshake -> all outputs 0 immediately; after release, next request completes normally.
